// File: rtl/sys_timer_irq_if.sv
// Purpose : CPU register window, timebase and IRQ lines of the system timer/IRQ controller.
// Latency : pure wiring; timing is set by the module that owns the slave modport.
// Backpressure: none; one access per clk, no stall path.
// Signals : tick_en (timebase enable), cs/we/addr/din (register access), dout (read data),
//           ext_irq (edge sources), irq (level IRQ to CPU), tmr_expired (per-timer expiry pulse).
interface sys_timer_irq_if #(
    parameter int NUM_TIMERS = 2,
    parameter int NUM_EXT    = 2,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3
);
    logic                  tick_en;
    logic                  cs;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic [NUM_EXT-1:0]    ext_irq;
    logic                  irq;
    logic [NUM_TIMERS-1:0] tmr_expired;

    modport master (
        output tick_en, cs, we, addr, din, ext_irq,
        input  dout, irq, tmr_expired
    );

    modport slave (
        input  tick_en, cs, we, addr, din, ext_irq,
        output dout, irq, tmr_expired
    );
endinterface

// File: rtl/sys_timer_irq.sv
// Purpose : NUM_TIMERS prescaled down-counters plus NUM_EXT rising-edge sources merged into one level IRQ.
// Latency : reads land on dout 1 clk after cs&~we; irq follows pending by 1 clk; tmr_expired pulses the clk after expiry.
// Backpressure: none; every register access completes in one clk.
// Ports   : clk, reset (async, active high); bus (slave) = tick_en, cs, we, addr, din, dout, ext_irq, irq, tmr_expired.
// Map     : 0 IRQ_EN, 1 IRQ_STAT (W1C), 2 PSEL, 3 RMODE, 4+k TMR_k; everything else reads 0.
module sys_timer_irq #(
    parameter int NUM_TIMERS     = 2,
    parameter int NUM_EXT        = 2,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 3,
    parameter int PRESCALE_SHORT = 255,
    parameter int PRESCALE_LONG  = 16383
) (
    input logic            clk,
    input logic            reset,
    sys_timer_irq_if.slave bus
);
    localparam int NSRC  = NUM_TIMERS + NUM_EXT;
    localparam int PRE_W = $clog2(PRESCALE_LONG + 1);
    localparam logic [PRE_W-1:0] PRE_SHORT = PRE_W'(PRESCALE_SHORT);
    localparam logic [PRE_W-1:0] PRE_LONG  = PRE_W'(PRESCALE_LONG);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;

    tmr_state_e                        r_state [NUM_TIMERS];
    tmr_state_e                        w_state_nxt [NUM_TIMERS];
    logic [NUM_TIMERS-1:0][DATA_W-1:0] r_count, w_count_nxt;
    logic [NUM_TIMERS-1:0][DATA_W-1:0] r_reload, w_reload_nxt;
    logic [NUM_TIMERS-1:0][PRE_W-1:0]  r_pre, w_pre_nxt, w_pre_sel;
    logic [NUM_TIMERS-1:0]             w_tmr_set;
    logic [NUM_TIMERS-1:0]             w_wr_tmr;

    logic [NSRC-1:0]       r_irq_en, r_pend, w_pend_nxt, w_set, w_w1c;
    logic [NUM_TIMERS-1:0] r_psel, r_rmode, r_expired;
    logic [NUM_EXT-1:0]    r_ext_prev, w_ext_edge;
    logic [DATA_W-1:0]     r_dout, w_rdata;
    logic                  r_irq;
    logic                  w_wr, w_rd;

    assign w_wr = bus.cs & bus.we;
    assign w_rd = bus.cs & ~bus.we;

    // Per-timer reload value for the prescaler, sampled whenever it reloads so a
    // PSEL change lands at the next step boundary rather than mid-interval.
    always_comb begin
        w_pre_sel = '0;
        w_wr_tmr  = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            w_pre_sel[k] = r_psel[k] ? PRE_LONG : PRE_SHORT;
            w_wr_tmr[k]  = w_wr && (bus.addr == ADDR_W'(4 + k));
        end
    end

    // Timer next-state: a CPU write to TMR_k overrides any step of that timer in the same clk.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_pre_nxt    = r_pre;
        w_tmr_set    = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (w_wr_tmr[k]) begin
                w_reload_nxt[k] = bus.din;
                w_count_nxt[k]  = bus.din;
                w_pre_nxt[k]    = w_pre_sel[k];
                if (bus.din == '0) begin
                    // Loading zero is an immediate expiry without ever running.
                    w_state_nxt[k] = IDLE;
                    w_tmr_set[k]   = 1'b1;
                end else begin
                    w_state_nxt[k] = RUN;
                end
            end else if ((r_state[k] == RUN) && bus.tick_en) begin
                if (r_pre[k] == '0) begin
                    w_pre_nxt[k] = w_pre_sel[k];
                    if (r_count[k] == DATA_W'(1)) begin
                        w_tmr_set[k] = 1'b1;
                        if (r_rmode[k]) begin
                            w_count_nxt[k] = r_reload[k];
                        end else begin
                            w_count_nxt[k] = '0;
                            w_state_nxt[k] = IDLE;
                        end
                    end else begin
                        w_count_nxt[k] = r_count[k] - DATA_W'(1);
                    end
                end else begin
                    w_pre_nxt[k] = r_pre[k] - PRE_W'(1);
                end
            end
        end
    end

    // New pending sources win over a simultaneous write-1-to-clear.
    assign w_ext_edge = bus.ext_irq & ~r_ext_prev;
    assign w_set      = {w_ext_edge, w_tmr_set};
    assign w_w1c      = (w_wr && (bus.addr == ADDR_W'(1))) ? bus.din[NSRC-1:0] : '0;
    assign w_pend_nxt = (r_pend & ~w_w1c) | w_set;

    always_comb begin
        w_rdata = '0;
        if (bus.addr == ADDR_W'(0)) w_rdata[NSRC-1:0]       = r_irq_en;
        if (bus.addr == ADDR_W'(1)) w_rdata[NSRC-1:0]       = r_pend;
        if (bus.addr == ADDR_W'(2)) w_rdata[NUM_TIMERS-1:0] = r_psel;
        if (bus.addr == ADDR_W'(3)) w_rdata[NUM_TIMERS-1:0] = r_rmode;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (bus.addr == ADDR_W'(4 + k)) w_rdata = r_count[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TIMERS; k++) r_state[k] <= IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_pre      <= '0;
            r_irq_en   <= '0;
            r_pend     <= '0;
            r_psel     <= '0;
            r_rmode    <= '0;
            r_expired  <= '0;
            r_ext_prev <= '0;
            r_dout     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_pre      <= w_pre_nxt;
            r_pend     <= w_pend_nxt;
            r_expired  <= w_tmr_set;
            r_ext_prev <= bus.ext_irq;
            // Uses the current pending/mask, so irq trails a pending set by one clk.
            r_irq      <= |(r_pend & r_irq_en);
            if (w_wr && (bus.addr == ADDR_W'(0))) r_irq_en <= bus.din[NSRC-1:0];
            if (w_wr && (bus.addr == ADDR_W'(2))) r_psel   <= bus.din[NUM_TIMERS-1:0];
            if (w_wr && (bus.addr == ADDR_W'(3))) r_rmode  <= bus.din[NUM_TIMERS-1:0];
            if (w_rd) r_dout <= w_rdata;
        end
    end

    assign bus.dout        = r_dout;
    assign bus.irq         = r_irq;
    assign bus.tmr_expired = r_expired;
endmodule

// File: tb/tb_sys_timer_irq.sv
// Purpose : self-checking bench for sys_timer_irq with a tick-scheduled reference model.
// Latency : model predicts registered outputs one clk after the inputs that cause them.
// Backpressure: none modelled; the register window never stalls.
module tb_sys_timer_irq;
    localparam int NT = 2;
    localparam int NE = 2;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int PS = 3;
    localparam int PL = 7;
    localparam int NS = NT + NE;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sys_timer_irq_if #(.NUM_TIMERS(NT), .NUM_EXT(NE), .DATA_W(DW), .ADDR_W(AW)) bus ();

    sys_timer_irq #(
        .NUM_TIMERS(NT), .NUM_EXT(NE), .DATA_W(DW), .ADDR_W(AW),
        .PRESCALE_SHORT(PS), .PRESCALE_LONG(PL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each running timer remembers the absolute tick number of its next step.
    logic [NS-1:0] m_en    = '0;
    logic [NS-1:0] m_pend  = '0;
    logic [NT-1:0] m_psel  = '0;
    logic [NT-1:0] m_rmode = '0;
    logic [NE-1:0] m_prev  = '0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_irq   = 1'b0;
    logic [NT-1:0] m_exp   = '0;
    bit            m_armed [NT];
    int            m_count [NT];
    int            m_reload[NT];
    longint        m_next  [NT];
    longint        m_ticks = 0;

    function automatic longint period(input int k);
        return longint'((m_psel[k] ? PL : PS) + 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_en = '0; m_pend = '0; m_psel = '0; m_rmode = '0; m_prev = '0;
            m_dout = '0; m_irq = 1'b0; m_exp = '0;
            for (int k = 0; k < NT; k++) begin
                m_armed[k] = 1'b0; m_count[k] = 0; m_reload[k] = 0;
            end
        end else begin
            logic [NS-1:0] s_set;
            logic [NS-1:0] s_w1c;
            logic [DW-1:0] rdv;
            logic          irq_n;
            int            a;
            bit            wr;
            a  = int'(bus.addr);
            wr = bus.cs && bus.we;
            rdv = '0;
            case (a)
                0: rdv = DW'(m_en);
                1: rdv = DW'(m_pend);
                2: rdv = DW'(m_psel);
                3: rdv = DW'(m_rmode);
                default: if (a >= 4 && a < 4 + NT) rdv = DW'(m_count[a-4]);
            endcase
            if (bus.cs && !bus.we) m_dout = rdv;
            irq_n = |(m_pend & m_en);
            if (bus.tick_en) m_ticks++;
            s_set = '0;
            for (int k = 0; k < NT; k++) begin
                if (wr && a == 4 + k) begin
                    m_count[k]  = int'(bus.din);
                    m_reload[k] = int'(bus.din);
                    if (bus.din == '0) begin
                        m_armed[k] = 1'b0;
                        s_set[k]   = 1'b1;
                    end else begin
                        m_armed[k] = 1'b1;
                        m_next[k]  = m_ticks + period(k);
                    end
                end else if (m_armed[k] && bus.tick_en && m_ticks == m_next[k]) begin
                    m_next[k] = m_ticks + period(k);
                    if (m_count[k] == 1) begin
                        s_set[k] = 1'b1;
                        if (m_rmode[k]) m_count[k] = m_reload[k];
                        else begin
                            m_count[k] = 0;
                            m_armed[k] = 1'b0;
                        end
                    end else begin
                        m_count[k] = m_count[k] - 1;
                    end
                end
            end
            m_exp = s_set[NT-1:0];
            s_set = s_set | (NS'(bus.ext_irq & ~m_prev) << NT);
            m_prev = bus.ext_irq;
            s_w1c = (wr && a == 1) ? bus.din[NS-1:0] : '0;
            m_pend = (m_pend & ~s_w1c) | s_set;
            if (wr && a == 0) m_en    = bus.din[NS-1:0];
            if (wr && a == 2) m_psel  = bus.din[NT-1:0];
            if (wr && a == 3) m_rmode = bus.din[NT-1:0];
            m_irq = irq_n;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("dout", int'(bus.dout), int'(m_dout));
            check("irq", int'(bus.irq), int'(m_irq));
            check("tmr_expired", int'(bus.tmr_expired), int'(m_exp));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = AW'(a); bus.din = DW'(d);
        cyc();
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = AW'(a);
        cyc();
        bus.cs = 1'b0;
        d = int'(bus.dout);
    endtask

    // Advance until tmr_expired[k] is seen, counting cycles into n; bounded by limit.
    task automatic wait_exp(input int k, input int limit, inout int n);
        int i;
        i = 0;
        while (!bus.tmr_expired[k] && i < limit) begin
            cyc();
            n++;
            i++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d, n, cnt;
        bus.tick_en = 1'b1; bus.cs = 1'b0; bus.we = 1'b0;
        bus.addr = '0; bus.din = '0; bus.ext_irq = '0;
        #1 reset = 1'b1;
        repeat (3) cyc();
        check("reset_dout", int'(bus.dout), 0);
        check("reset_irq", int'(bus.irq), 0);
        check("reset_exp", int'(bus.tmr_expired), 0);
        reset = 1'b0;
        cyc();

        // One-shot timer 0, short prescale: 2 steps x 4 ticks.
        wr(0, 1);
        wr(4, 2);
        n = 0;
        wait_exp(0, 100, n);
        check("oneshot_latency", n, 8);
        check("irq_lags_pending", int'(bus.irq), 0);
        cyc();
        check("irq_after_pending", int'(bus.irq), 1);
        rd(1, d);
        check("stat_after_expiry", d, 1);
        wr(1, 1);
        cyc();
        check("irq_after_w1c", int'(bus.irq), 0);
        cnt = 0;
        repeat (20) begin cyc(); if (bus.tmr_expired[0]) cnt++; end
        check("no_reexpiry_oneshot", cnt, 0);

        // Periodic timer 1, long prescale: 3 steps x 8 ticks.
        wr(3, 2);
        wr(2, 2);
        wr(5, 3);
        n = 0;
        rd(5, d); n++;
        check("tmr1_read_start", d, 3);
        wait_exp(1, 100, n);
        check("periodic_first", n, 24);
        rd(5, d);
        check("tmr1_after_reload", d, 3);
        repeat (7) cyc();
        rd(5, d);
        check("tmr1_after_step", d, 2);
        n = 9;
        wait_exp(1, 100, n);
        check("periodic_second", n, 24);
        wr(5, 0);
        wr(1, 'hF);
        wr(3, 0);
        wr(2, 0);

        // Zero write expires immediately and leaves the timer idle.
        wr(4, 0);
        check("zero_write_pulse", int'(bus.tmr_expired[0]), 1);
        rd(1, d);
        check("zero_write_pending", d, 1);
        rd(4, d);
        check("zero_write_count", d, 0);
        wr(4, 5);
        n = 0;
        wait_exp(0, 100, n);
        check("rearm_latency", n, 20);
        wr(1, 'hF);

        // Masked external edge, then unmask; held level does not retrigger.
        wr(0, 0);
        bus.ext_irq = 2'b01;
        cyc();
        bus.ext_irq = 2'b00;
        cyc();
        rd(1, d);
        check("ext_pending", d, 4);
        check("ext_masked_irq", int'(bus.irq), 0);
        wr(0, 4);
        check("unmask_lag", int'(bus.irq), 0);
        cyc();
        check("unmask_irq", int'(bus.irq), 1);
        bus.ext_irq = 2'b01;
        cyc();
        wr(1, 4);
        repeat (5) cyc();
        rd(1, d);
        check("held_level_no_retrigger", d, 0);
        check("held_level_irq", int'(bus.irq), 0);
        bus.ext_irq = 2'b00;

        // W1C on the expiry clk: set wins.
        wr(0, 1);
        wr(4, 1);
        repeat (3) cyc();
        wr(1, 1);
        check("collide_pulse", int'(bus.tmr_expired[0]), 1);
        rd(1, d);
        check("collide_w1c_set_wins", d, 1);
        wr(1, 1);
        // TMR write on the expiry clk: write wins, no pending.
        wr(4, 1);
        repeat (3) cyc();
        wr(4, 4);
        check("collide_write_no_pulse", int'(bus.tmr_expired[0]), 0);
        rd(1, d);
        check("collide_write_no_pending", d, 0);
        rd(4, d);
        check("collide_write_count", d, 4);

        // Reset while both timers run and irq is high.
        wr(0, 3);
        wr(3, 3);
        wr(4, 0);
        wr(4, 3);
        wr(5, 2);
        cyc();
        check("pre_reset_irq", int'(bus.irq), 1);
        rd(5, d);
        check("pre_reset_dout", d, 2);
        reset = 1'b1;
        #1;
        check("async_reset_dout", int'(bus.dout), 0);
        check("async_reset_irq", int'(bus.irq), 0);
        check("async_reset_exp", int'(bus.tmr_expired), 0);
        repeat (2) cyc();
        reset = 1'b0;
        cnt = 0;
        repeat (100) begin cyc(); if (bus.tmr_expired != '0 || bus.irq) cnt++; end
        check("post_reset_quiet", cnt, 0);
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            check("post_reset_reg", d, 0);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.tick_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) bus.ext_irq = NE'($urandom);
            bus.cs   = ($urandom_range(0, 3) == 0);
            bus.we   = 1'($urandom_range(0, 1));
            bus.addr = AW'($urandom);
            bus.din  = (bus.addr >= AW'(4)) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            reset    = ($urandom_range(0, 799) == 0);
            cyc();
        end
        reset = 1'b0;
        bus.cs = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_timer_irq.md
Name: sys_timer_irq

Overview:
Parametrised multi-channel system timer and interrupt controller for the Supervision core. It replaces the single hard-wired 8-bit timer and IRQ status logic in the emu top. It provides NUM_TIMERS down-counters with selectable prescalers, one-shot or periodic mode, and NUM_EXT external edge-triggered sources, such as DMA done. All sources merge into one level IRQ to the 65C02, and the block is accessed through a small CPU register window.

Parameters:
NUM_TIMERS, 2, number of timer channels (1..4)
NUM_EXT, 2, number of external IRQ inputs; NUM_TIMERS+NUM_EXT <= DATA_W
DATA_W, 8, register/bus width and timer counter width
ADDR_W, 3, register address width; requires 4+NUM_TIMERS <= 2**ADDR_W
PRESCALE_SHORT, 255, prescaler reload value, short mode (step every 256 ticks)
PRESCALE_LONG, 16383, prescaler reload value, long mode (step every 16384 ticks)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
tick_en  in  1  one-clk timebase enable at CPU rate
cs  in  1  register window select
we  in  1  1=write, 0=read (valid when cs=1)
addr  in  ADDR_W  register index
din  in  DATA_W  write data
dout  out  DATA_W  read data, registered
ext_irq  in  NUM_EXT  external IRQ sources, rising-edge sensitive
irq  out  1  registered level IRQ to CPU
tmr_expired  out  NUM_TIMERS  one-clk pulse per timer expiry

Behaviour:
- Source index: bits [NUM_TIMERS-1:0] are timers; bits [NUM_TIMERS+NUM_EXT-1:NUM_TIMERS] are external inputs.
- Register map:
  - 0 IRQ_EN: mask, R/W.
  - 1 IRQ_STAT: pending bits on read; write-1-to-clear.
  - 2 PSEL: bit k=1 selects long prescale for timer k.
  - 3 RMODE: bit k=1 selects periodic mode for timer k.
  - 4+k TMR_k: write loads reload_k and count_k; read returns live count_k.
  - Unused bits and addresses read 0; writes to them are ignored.
- Reset: all registers, counters, prescalers, armed flags, ext edge history, irq, dout and tmr_expired are 0. No expiry can occur from reset state.
- Each timer has a state `armed`:
  - IDLE (armed=0) goes to RUN on a write of a non-zero value to TMR_k. The prescaler reloads from the selected PSEL value.
  - A write of 0 to TMR_k sets pending[k] and pulses tmr_expired[k] on the next clk. The timer stays IDLE.
  - RUN, on a tick_en with prescaler==0: prescaler reloads and count decrements. Any other tick_en in RUN only decrements the prescaler.
  - A count step 1->0 is an expiry: pending[k]<=1 and a tmr_expired[k] pulse.
    - One-shot mode: go to IDLE with count=0.
    - Periodic mode: count<=reload_k and stay in RUN.
  - The count step interval is (P+1) tick_en pulses, where P is the PSEL-selected value.
  - Changing PSEL while in RUN takes effect at the next prescaler reload.
- External sources: ext_irq is sampled each clk. A 0->1 transition sets the corresponding pending bit in the same cycle the edge is detected. Levels held high do not retrigger.
- irq <= |(pending & IRQ_EN), registered, so irq follows a pending set by 1 clk. Pending bits set while masked remain set and assert irq when unmasked.
- Reads: when cs & ~we, dout <= register[addr] on the next clk. Otherwise dout holds its value.
- Simultaneous events:
  - A pending set in the same clk as a W1C of that bit: set wins and the bit stays 1.
  - A TMR_k write in the same clk as an expiry of timer k: the write wins. No pending is set unless the written value is 0.
  - A W1C of pending and IRQ_EN=0 in the same clk: both apply.
- tick_en with cs&we in the same clk: register writes take priority over counting for the addressed timer only. Other timers count normally.
- Reset mid-operation aborts all timers immediately and returns them to IDLE. Pending and irq clear asynchronously.

Test Plan:
- Bench parameters PRESCALE_SHORT=3, PRESCALE_LONG=7, tick_en every clk. Write IRQ_EN=0x01, TMR_0=2 in one-shot mode -> tmr_expired[0] pulses 8 ticks after the write. IRQ_STAT reads 0x01, irq=1 one clk after pending. W1C 0x01 -> irq=0 and no further expiry.
- Periodic: RMODE=0x02, PSEL=0x02, TMR_1=3 -> tmr_expired[1] every 24 ticks. TMR_1 reads 3,2,1,3,... at step boundaries.
- Write TMR_0=0 -> pending[0]=1 next clk, timer stays IDLE, count reads 0. A second write of 5 arms a normal countdown.
- Masking and edges: IRQ_EN=0, pulse ext_irq[0] -> IRQ_STAT=0x04, irq=0. Set IRQ_EN=0x04 -> irq=1 after 1 clk. Holding ext_irq[0] high after W1C -> no re-set.
- Collision: schedule the W1C of bit0 on the exact expiry clk -> pending[0] remains 1. Schedule a TMR_0=4 write on the expiry clk -> no pending and count=4.
- Assert reset while both timers run with irq=1 -> all outputs 0 immediately. After release, no spurious expiry for 100 ticks.
